core_dbus: RTL and testbench

Data-side bus block placed directly downstream of the single-cycle core's data port. It decodes the core's memory address and routes each word access to one of two targets: a local data RAM, or a small set of memory-mapped registers. The registers are an LED register, a free-running cycle timer, and a transmit FIFO that feeds a downstream UART through a valid/ready handshake. Read data returns combinationally so the core completes loads in its single cycle.

---
 rtl/core_dbus_pkg.sv | 26 ++
 rtl/sync_fifo.sv | 54 +++++
 rtl/core_dbus.sv | 130 +++++++++++++
 tb/tb_core_dbus.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/core_dbus_pkg.sv
// Shared constants and types for the data-side bus: MMIO address map,
// STATUS bit layout and the decode target select.
package core_dbus_pkg;

    localparam logic [31:0] MMIO_BASE   = 32'h8000_0000;
    localparam logic [31:0] LED_ADDR    = MMIO_BASE + 32'h0000_0000;
    localparam logic [31:0] TIMER_ADDR  = MMIO_BASE + 32'h0000_0004;
    localparam logic [31:0] TXDATA_ADDR = MMIO_BASE + 32'h0000_0008;
    localparam logic [31:0] STATUS_ADDR = MMIO_BASE + 32'h0000_000C;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 4;
    localparam int STAT_CNT_W   = 4;

    typedef enum logic [2:0] {
        SEL_RAM,
        SEL_LED,
        SEL_TIMER,
        SEL_TXDATA,
        SEL_STATUS,
        SEL_NONE
    } sel_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered head. A push into a full FIFO is accepted
// when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head reads as zero while empty so a flushed FIFO presents clean data.
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/core_dbus.sv
// Data-side bus: decodes core word accesses into local RAM or MMIO
// (LED, free-running timer, TX FIFO, status) with a combinational read mux.
module core_dbus
    import core_dbus_pkg::*;
#(
    parameter int DMEM_WORDS = 256,
    parameter int TXQ_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] ALUResult,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic [7:0]  led,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int AW  = $clog2(DMEM_WORDS);
    localparam int QCW = $clog2(TXQ_DEPTH) + 1;

    sel_t            sel;
    logic [31:0]     word_addr;
    logic [AW-1:0]   ram_idx;
    logic [31:0]     mem [DMEM_WORDS];
    logic [31:0]     timer;
    logic            overflow;
    logic [31:0]     status;

    logic            we_ram;
    logic            we_led;
    logic            we_timer;
    logic            we_txdata;
    logic            we_status;

    logic            q_full;
    logic            q_empty;
    logic [QCW-1:0]  q_count;
    logic            q_pop;
    logic            ovf_event;

    assign word_addr = {ALUResult[31:2], 2'b00};
    assign ram_idx   = ALUResult[AW+1:2];

    always_comb begin
        sel = SEL_NONE;
        if (ALUResult[31:AW+2] == '0) begin
            sel = SEL_RAM;
        end else begin
            case (word_addr)
                LED_ADDR:    sel = SEL_LED;
                TIMER_ADDR:  sel = SEL_TIMER;
                TXDATA_ADDR: sel = SEL_TXDATA;
                STATUS_ADDR: sel = SEL_STATUS;
                default:     sel = SEL_NONE;
            endcase
        end
    end

    assign we_ram    = MemWrite && (sel == SEL_RAM);
    assign we_led    = MemWrite && (sel == SEL_LED);
    assign we_timer  = MemWrite && (sel == SEL_TIMER);
    assign we_txdata = MemWrite && (sel == SEL_TXDATA);
    assign we_status = MemWrite && (sel == SEL_STATUS);

    assign q_pop     = tx_valid && tx_ready;
    assign ovf_event = we_txdata && q_full && !q_pop;
    assign tx_valid  = !q_empty;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (TXQ_DEPTH)
    ) u_txq (
        .clk       (clk),
        .reset     (reset),
        .push      (we_txdata),
        .push_data (WriteData[7:0]),
        .pop       (q_pop),
        .full      (q_full),
        .empty     (q_empty),
        .count     (q_count),
        .head      (tx_data)
    );

    // RAM is not reset, but a write coinciding with reset is still suppressed.
    always_ff @(posedge clk) begin
        if (!reset && we_ram) begin
            mem[ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led      <= '0;
            timer    <= '0;
            overflow <= 1'b0;
        end else begin
            if (we_led) begin
                led <= WriteData[7:0];
            end
            timer <= we_timer ? 32'h0 : timer + 32'h1;
            if (we_status) begin
                overflow <= 1'b0;
            end else if (ovf_event) begin
                overflow <= 1'b1;
            end
        end
    end

    always_comb begin
        status                                = '0;
        status[STAT_FULL]                     = q_full;
        status[STAT_EMPTY]                    = q_empty;
        status[STAT_OVF]                      = overflow;
        status[STAT_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(q_count);
    end

    always_comb begin
        case (sel)
            SEL_RAM:    ReadData = mem[ram_idx];
            SEL_LED:    ReadData = {24'h0, led};
            SEL_TIMER:  ReadData = timer;
            SEL_STATUS: ReadData = status;
            default:    ReadData = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_core_dbus.sv
// Directed bench for core_dbus: inputs change just after the falling edge,
// outputs are sampled 1 time unit later, well away from the rising edge.
module tb_core_dbus;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWrite;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic [7:0]  led;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;

    int total = 0;
    int bad   = 0;

    localparam logic [31:0] A_LED    = 32'h8000_0000;
    localparam logic [31:0] A_TIMER  = 32'h8000_0004;
    localparam logic [31:0] A_TXDATA = 32'h8000_0008;
    localparam logic [31:0] A_STATUS = 32'h8000_000C;

    core_dbus dut (
        .clk       (clk),
        .reset     (reset),
        .MemWrite  (MemWrite),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .led       (led),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .tx_ready  (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        MemWrite  = 1'b1;
        ALUResult = addr;
        WriteData = data;
        @(negedge clk);
        MemWrite  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        ALUResult = addr;
        #1;
        chk(tag, ReadData, exp);
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        ALUResult = 32'h0;
        WriteData = 32'h0;
        tx_ready  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: reset state
        rd("rst_status", A_STATUS, 32'h0000_0002);
        rd("rst_led", A_LED, 32'h0);
        rd("rst_timer", A_TIMER, 32'h0);
        chk("rst_tx_valid", {31'h0, tx_valid}, 32'h0);
        chk("rst_tx_data", {24'h0, tx_data}, 32'h0);

        // 2: RAM
        wr(32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_10", 32'h0000_0010, 32'hDEAD_BEEF);
        rd("ram_13", 32'h0000_0013, 32'hDEAD_BEEF);
        wr(32'h0000_0014, 32'h0000_0001);
        rd("ram_14", 32'h0000_0014, 32'h0000_0001);
        rd("ram_10_kept", 32'h0000_0010, 32'hDEAD_BEEF);
        wr(32'h0000_03FC, 32'h1234_5678);
        rd("ram_top", 32'h0000_03FC, 32'h1234_5678);
        rd("ram_out_of_range", 32'h0000_0400, 32'h0);

        // LED: only low byte stored
        wr(A_LED, 32'hFFFF_FF5A);
        rd("led_read", A_LED, 32'h0000_005A);
        chk("led_port", {24'h0, led}, 32'h5A);

        // 3: fill and overflow with tx_ready low
        wr(A_TXDATA, 32'h41);
        chk("tx_valid_after_push", {31'h0, tx_valid}, 32'h1);
        wr(A_TXDATA, 32'h42);
        wr(A_TXDATA, 32'h43);
        wr(A_TXDATA, 32'h44);
        wr(A_TXDATA, 32'h45);
        rd("status_full_ovf", A_STATUS, 32'h0000_0045);
        rd("txdata_reads_zero", A_TXDATA, 32'h0);
        chk("head_held", {24'h0, tx_data}, 32'h41);
        tx_ready = 1'b1;
        #1;
        chk("drain0", {24'h0, tx_data}, 32'h41);
        @(negedge clk); #1;
        chk("drain1", {24'h0, tx_data}, 32'h42);
        @(negedge clk); #1;
        chk("drain2", {24'h0, tx_data}, 32'h43);
        @(negedge clk); #1;
        chk("drain3", {24'h0, tx_data}, 32'h44);
        @(negedge clk); #1;
        chk("drain_done_valid", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;
        rd("status_empty_ovf", A_STATUS, 32'h0000_0006);

        // 4: clear overflow, then push into full FIFO with a concurrent pop
        wr(A_STATUS, 32'h0);
        rd("status_ovf_cleared", A_STATUS, 32'h0000_0002);
        wr(A_TXDATA, 32'h61);
        wr(A_TXDATA, 32'h62);
        wr(A_TXDATA, 32'h63);
        wr(A_TXDATA, 32'h64);
        rd("status_full_noovf", A_STATUS, 32'h0000_0041);
        tx_ready = 1'b1;
        wr(A_TXDATA, 32'h55);
        tx_ready = 1'b0;
        rd("status_push_pop_full", A_STATUS, 32'h0000_0041);
        chk("head_after_push_pop", {24'h0, tx_data}, 32'h62);
        tx_ready = 1'b1;
        @(negedge clk); #1;
        chk("order_63", {24'h0, tx_data}, 32'h63);
        @(negedge clk); #1;
        chk("order_64", {24'h0, tx_data}, 32'h64);
        @(negedge clk); #1;
        chk("order_55", {24'h0, tx_data}, 32'h55);
        @(negedge clk); #1;
        chk("order_empty", {31'h0, tx_valid}, 32'h0);
        tx_ready = 1'b0;

        // 5: timer
        wr(A_TIMER, 32'hFFFF_FFFF);
        rd("timer_cleared", A_TIMER, 32'h0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rd("timer_plus3", A_TIMER, 32'h3);
        force dut.timer = 32'hFFFF_FFFF;
        rd("timer_forced", A_TIMER, 32'hFFFF_FFFF);
        release dut.timer;
        @(negedge clk);
        rd("timer_wrap", A_TIMER, 32'h0);

        // 6: reset mid-transfer, reset beats a concurrent LED write
        wr(A_TXDATA, 32'h71);
        wr(A_TXDATA, 32'h72);
        wr(A_TXDATA, 32'h73);
        rd("status_three", A_STATUS, 32'h0000_0030);
        reset     = 1'b1;
        MemWrite  = 1'b1;
        ALUResult = A_LED;
        WriteData = 32'hFF;
        @(negedge clk);
        reset    = 1'b0;
        MemWrite = 1'b0;
        #1;
        chk("reset_flush_valid", {31'h0, tx_valid}, 32'h0);
        chk("reset_flush_data", {24'h0, tx_data}, 32'h0);
        chk("reset_beats_write", {24'h0, led}, 32'h0);
        rd("reset_status", A_STATUS, 32'h0000_0002);

        wr(32'h0000_0000, 32'hCAFE_F00D);
        wr(A_LED, 32'h3C);
        wr(32'h4000_0000, 32'hFFFF_FFFF);
        rd("unmapped_read", 32'h4000_0000, 32'h0);
        rd("unmapped_ram0", 32'h0000_0000, 32'hCAFE_F00D);
        rd("unmapped_led", A_LED, 32'h0000_003C);
        rd("unmapped_status", A_STATUS, 32'h0000_0002);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
